// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the CPU datapath.
//   - R-type funct codes for the HI/LO instruction group
//   - state encoding for the iterative multiply/divide unit
package cpu_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative unsigned multiply/divide unit in the EX stage.
// Owns the architectural HI/LO registers.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   valid_in     ID/EX holds a live R-type instruction
//   funct_in     ID/EX funct field
//   rs_val       dividend / multiplicand / MTHI-MTLO source
//   rt_val       divisor / multiplier
//   busy         combinational stall request to the hazard unit
//   done         one-cycle pulse when a MULTU/DIVU result lands in HI/LO
//   div0         sticky divide-by-zero flag, cleared by next MULTU/DIVU
//   hi, lo       HI/LO register outputs
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [5:0]       funct_in,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import cpu_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_e state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator / remainder:quotient
    logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand, or divisor during DIVU
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div0_q, div0_d, done_q, done_d;

    logic               is_mul, is_div, rt_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_up, div_trial;
    logic [2*WIDTH-1:0] div_rem;

    always_comb begin
        is_mul  = (funct_in == FUNCT_MULTU);
        is_div  = (funct_in == FUNCT_DIVU);
        rt_zero = (rt_val == '0);

        // Multiply step: add into upper half with carry, then shift the whole
        // {carry, acc} right so the carry drops into the top bit.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide step: the bit shifted out of the upper half is kept
        // as bit WIDTH of the trial, so its sign bit is a valid borrow flag.
        div_up    = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_up - {1'b0, mcand_q};
        div_rem   = div_trial[WIDTH]
                  ? {acc_q[2*WIDTH-2:0], 1'b0}
                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        busy     = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (valid_in) begin
                    if (is_mul) begin
                        busy     = 1'b1;
                        mcand_d  = rs_val;
                        mplier_d = rt_val;
                        acc_d    = '0;
                        count_d  = '0;
                        div0_d   = 1'b0;
                        state_d  = MD_MUL;
                    end else if (is_div) begin
                        if (!rt_zero) begin
                            busy    = 1'b1;
                            mcand_d = rt_val;
                            acc_d   = {{WIDTH{1'b0}}, rs_val};
                            count_d = '0;
                            div0_d  = 1'b0;
                            state_d = MD_DIV;
                        end else begin
                            hi_d   = rs_val;
                            lo_d   = '1;
                            div0_d = 1'b1;
                            done_d = 1'b1;
                        end
                    end else if (funct_in == FUNCT_MTHI) begin
                        hi_d = rs_val;
                    end else if (funct_in == FUNCT_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            MD_MUL: begin
                busy     = 1'b1;
                acc_d    = mul_acc;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    hi_d    = mul_acc[2*WIDTH-1:WIDTH];
                    lo_d    = mul_acc[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                busy    = 1'b1;
                acc_d   = div_rem;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    hi_d    = div_rem[2*WIDTH-1:WIDTH];
                    lo_d    = div_rem[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = MD_DONE;
                end
            end
            // The issuing instruction is still in ID/EX here; ignore it.
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  funct_in;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;
    int n;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .funct_in (funct_in),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .done     (done),
        .div0     (div0),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1;
        funct_in = f;
        rs_val   = a;
        rt_val   = b;
        #1;
    endtask

    // Called in C0 with busy already checked; counts busy cycles (C0 included)
    // and returns in the first non-busy cycle. Bounded so a hung unit still ends.
    task automatic wait_idle(output int cnt);
        cnt = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!busy) break;
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; funct_in = '0; rs_val = '0; rt_val = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_hi",   hi,   0);
        chk("rst_lo",   lo,   0);

        // Unrelated funct: ignored
        issue(6'h20, 32'hDEAD_BEEF, 32'h1);
        chk("other_busy", busy, 0);
        tick();
        chk("other_hi", hi, 0);
        chk("other_lo", lo, 0);

        // MULTU max x max, held through DONE
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul1_c0_busy", busy, 1);
        wait_idle(n);
        chk("mul1_busy_cycles", n, 33);
        chk("mul1_done", done, 1);
        chk("mul1_hi", hi, 32'hFFFF_FFFE);
        chk("mul1_lo", lo, 32'h0000_0001);
        tick();
        // C34: no restart happened in C33; new MULTU 2x3 is accepted here
        chk("mul1_c34_done", done, 0);
        issue(6'h19, 32'd2, 32'd3);
        chk("mul2_c0_busy", busy, 1);
        wait_idle(n);
        chk("mul2_busy_cycles", n, 33);
        chk("mul2_done", done, 1);
        chk("mul2_hi", hi, 0);
        chk("mul2_lo", lo, 6);
        tick();

        // DIVU 100 / 7
        issue(6'h1B, 32'd100, 32'd7);
        chk("div1_c0_busy", busy, 1);
        wait_idle(n);
        chk("div1_busy_cycles", n, 33);
        chk("div1_done", done, 1);
        chk("div1_lo", lo, 14);
        chk("div1_hi", hi, 2);
        chk("div1_div0", div0, 0);
        tick();

        // DIVU 0x80000000 / 1
        issue(6'h1B, 32'h8000_0000, 32'd1);
        wait_idle(n);
        chk("div2_busy_cycles", n, 33);
        chk("div2_lo", lo, 32'h8000_0000);
        chk("div2_hi", hi, 0);
        tick();

        // DIVU 5 / 0: no stall, results in C1
        issue(6'h1B, 32'd5, 32'd0);
        chk("dz_c0_busy", busy, 0);
        tick();
        chk("dz_hi",   hi,   5);
        chk("dz_lo",   lo,   32'hFFFF_FFFF);
        chk("dz_div0", div0, 1);
        chk("dz_done", done, 1);
        // Following MULTU 3x4 clears div0
        issue(6'h19, 32'd3, 32'd4);
        chk("dz_mul_busy", busy, 1);
        wait_idle(n);
        chk("dz_mul_cycles", n, 33);
        chk("dz_mul_div0", div0, 0);
        chk("dz_mul_lo", lo, 12);
        chk("dz_mul_hi", hi, 0);
        tick();

        // MTHI then MTLO back to back
        issue(6'h11, 32'h1234_5678, 32'h0);
        chk("mthi_busy", busy, 0);
        tick();
        chk("mthi_hi", hi, 32'h1234_5678);
        issue(6'h13, 32'h9ABC_DEF0, 32'h0);
        chk("mtlo_busy", busy, 0);
        tick();
        valid_in = 1'b0;
        #1;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mt_done", done, 0);

        // Reset at C10 of a MULTU
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("rmul_c0_busy", busy, 1);
        repeat (10) tick();
        chk("rmul_c10_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rmul_busy", busy, 0);
        chk("rmul_hi", hi, 0);
        chk("rmul_lo", lo, 0);
        chk("rmul_done", done, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) n++;
        end
        chk("rmul_no_done_later", n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative unsigned multiply/divide unit in the EX stage. It takes MULTU, DIVU, MTHI and MTLO from the ID/EX pipeline register outputs and owns the architectural HI/LO registers. While an operation is in flight it asserts `busy`, which the hazard logic uses to deassert `en_reg` on the PC, IF/ID and ID/EX registers. That holds the issuing instruction in ID/EX until the result is written.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: ID/EX holds a live R-type instruction (`op_out==0`, not a bubble).
- `funct_in` in 6: ID/EX `funct_out`.
- `rs_val` in WIDTH: ID/EX `RD1_out`, after forwarding; dividend, multiplicand, or MTHI/MTLO source.
- `rt_val` in WIDTH: ID/EX `RD2_out`, after forwarding; divisor or multiplier.
- `busy` out 1: stall request to the hazard unit; combinational.
- `done` out 1: one-cycle pulse when a MULTU or DIVU result lands in HI/LO.
- `div0` out 1: sticky; set when a DIVU has divisor 0; cleared by the next accepted MULTU or DIVU.
- `hi` out WIDTH: HI register, read by MFHI in the EX result mux.
- `lo` out WIDTH: LO register, read by MFLO.

## Operation
- Funct codes: MULTU 6'h19, DIVU 6'h1B, MTHI 6'h11, MTLO 6'h13. Any other funct is ignored.
- FSM states: IDLE, MUL, DIV, DONE.
- **IDLE**, `valid_in` with MULTU:
  - Latch mcand=`rs_val` and mplier=`rt_val`; clear the 2·WIDTH-bit accumulator and `count`.
  - Next state MUL.
- **IDLE**, `valid_in` with DIVU and `rt_val`≠0:
  - Latch divisor; set rem={WIDTH'0, `rs_val`}; clear `count`.
  - Next state DIV.
- **IDLE**, DIVU with `rt_val`==0:
  - No iteration. Next edge: HI←`rs_val`, LO←all ones, `div0`←1, `done`←1.
  - Stay in IDLE.
- **IDLE**, MTHI/MTLO: next edge HI (resp. LO)←`rs_val`. No busy, no done.
- **MUL**, one step per cycle:
  - If mplier[0], add mcand into the upper half of the accumulator, carry kept in WIDTH+1 bits.
  - Shift the accumulator right 1; shift mplier right 1; `count`++.
  - At `count`==WIDTH-1: HI←acc[2W-1:W], LO←acc[W-1:0]; next state DONE.
- **DIV**, restoring divider, one step per cycle:
  - Shift rem left 1; trial = rem[2W-1:W] − divisor, computed in WIDTH+1 bits.
  - If non-negative, upper half←trial and rem[0]←1; otherwise rem[0]←0. `count`++.
  - At `count`==WIDTH-1: HI←remainder, LO←quotient, from the post-step value; next state DONE.
- **DONE**: `done`=1, `busy`=0; next state IDLE unconditionally.
  - `valid_in` is ignored here. The same instruction is still in ID/EX this cycle and must not restart.
- `busy` = (IDLE && `valid_in` && (MULTU || (DIVU && `rt_val`≠0))) || MUL || DIV.
- MTHI/MTLO cannot arrive during MUL/DIV, because the front-end is stalled. No arbitration is required.
- Reset (any state, including mid-operation):
  - state←IDLE; HI, LO, `div0`, `done`, `count` and the datapath registers←0.
  - `busy` is 0 in the cycle after reset.

## Timing
- C0: acceptance cycle; `busy`=1 combinationally, so ID/EX does not advance.
- C1..C32 (WIDTH=32): iterations. HI/LO are written at the C32 edge.
- C33: DONE, `busy`=0, `done`=1, HI/LO valid. ID/EX advances at the end of C33.
- Total stall: WIDTH+1 cycles. A back-to-back MULTU/DIVU is accepted in C34 at the earliest.
- Divide-by-zero: zero stall; HI/LO, `div0` and `done` are visible in C1.
- MTHI/MTLO: HI/LO are updated at the C0 edge. An MFHI/MFLO in the following instruction reads the new value with no stall.
- `hi`/`lo` are register outputs and change only on the edges listed above.

## Structure
- Shared package `cpu_pkg` holds:
  - funct constants FUNCT_MULTU, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO, FUNCT_MFHI, FUNCT_MFLO;
  - the muldiv state encoding (2-bit: IDLE, MUL, DIV, DONE).
- Single module; no sub-module. The multiply and divide datapaths share the 2·WIDTH-bit accumulator/remainder register and the `count` counter of $clog2(WIDTH) bits.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high for exactly 33 cycles; in C33 `done`=1, HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100 / 7 -> in C33 LO=14, HI=2, `div0`=0. DIVU 0x80000000 / 1 -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> `busy` never high; in C1 HI=5, LO=0xFFFFFFFF, `div0`=1, `done`=1. A following MULTU 3×4 clears `div0` and gives LO=12.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> `hi`=0x12345678 and `lo`=0x9ABCDEF0 in the following cycle; `busy` never high.
- `rst` pulsed at C10 of a MULTU -> next cycle state IDLE, `busy`=0, HI=LO=0, no `done` pulse.
- `valid_in`/MULTU held through DONE, then a new MULTU 2×3 presented in C34 -> no restart in C33; second result LO=6, HI=0 in C67.
